// File: rtl/array_multiplier_pkg.sv
// array_multiplier_pkg: shared sizing helpers for the pipelined array multiplier
package array_multiplier_pkg;
  function automatic int mask_width(input int dw);
    return dw + 1;
  endfunction
  function automatic int popcount(input logic [63:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) if (m[i]) n++;
    return n;
  endfunction
endpackage

// File: rtl/mul_stage_comb.sv
// mul_stage_comb: adds one shifted partial-product row into the accumulator
module mul_stage_comb #(
  parameter int WIDTH = 8,
  parameter int ROW   = 0
) (
  input  logic [WIDTH-1:0]   A_in,
  input  logic [WIDTH-1:0]   B_in,
  input  logic [2*WIDTH-1:0] acc_in,
  output logic [2*WIDTH-1:0] acc_out
);
  logic b_sel;
  assign b_sel   = |(B_in & (WIDTH'(1) << ROW));
  assign acc_out = acc_in + (b_sel ? ((2*WIDTH)'(A_in) << ROW) : '0);
endmodule

// File: rtl/pipeline_stage.sv
// pipeline_stage: optional boundary register; a plain wire when ENABLE is 0
module pipeline_stage #(
  parameter int WIDTH  = 1,
  parameter bit ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  if (ENABLE) begin : g_reg
    logic [WIDTH-1:0] data_q;
    always_ff @(posedge clk or negedge rst)
      if (!rst) data_q <= '0;
      else data_q <= d_i;
    assign q_o = data_q;
  end else begin : g_wire
    logic unused_clk;
    assign unused_clk = clk ^ rst;
    assign q_o = d_i;
  end
endmodule

// File: rtl/array_multiplier.sv
// array_multiplier: shift-add multiplier with mask-selected pipeline cuts and saturated fixed-point result
module array_multiplier
  import array_multiplier_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int FRAC_BITS = 0,
  parameter logic [mask_width(DATAWIDTH)-1:0] PIPELINE_STAGE_MASK = '1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [DATAWIDTH-1:0]   A,
  input  logic [DATAWIDTH-1:0]   B,
  output logic                   o_valid,
  output logic [2*DATAWIDTH-1:0] P_out,
  output logic [DATAWIDTH-1:0]   Y_out,
  output logic                   ovf
);
  localparam int W  = DATAWIDTH;
  localparam int PW = 4 * W + 1;
  // payload per boundary: {acc, A, B, valid}
  for (genvar k = 0; k <= W; k++) begin : g_bnd
    logic [PW-1:0] stage_d;
    logic [PW-1:0] stage_q;
    if (k == 0) begin : g_in
      assign stage_d = {{(2*W){1'b0}}, A, B, i_valid};
    end else begin : g_row
      logic [2*W-1:0] acc;
      mul_stage_comb #(.WIDTH(W), .ROW(k - 1)) u_row (
        .A_in   (g_bnd[k-1].stage_q[2*W:W+1]),
        .B_in   (g_bnd[k-1].stage_q[W:1]),
        .acc_in (g_bnd[k-1].stage_q[PW-1:2*W+1]),
        .acc_out(acc)
      );
      assign stage_d = {acc, g_bnd[k-1].stage_q[2*W:0]};
    end
    pipeline_stage #(.WIDTH(PW), .ENABLE(PIPELINE_STAGE_MASK[k])) u_stage (
      .clk(clk),
      .rst(rst),
      .d_i(stage_d),
      .q_o(stage_q)
    );
  end
  logic [2*W-1:0] prod;
  logic           sat;
  logic           unused_ab;
  assign prod      = g_bnd[W].stage_q[PW-1:2*W+1];
  assign unused_ab = ^g_bnd[W].stage_q[2*W:1];
  assign sat       = |(prod >> (W + FRAC_BITS));
  assign o_valid   = g_bnd[W].stage_q[0];
  assign P_out     = o_valid ? prod : '0;
  assign ovf       = o_valid & sat;
  assign Y_out     = !o_valid ? '0 : sat ? '1 : W'(prod >> FRAC_BITS);
endmodule

// File: tb/tb_array_multiplier.sv
// tb_array_multiplier: directed and random checks of four mask/fixed-point variants against an arithmetic model
module tb_array_multiplier;
  import array_multiplier_pkg::*;
  localparam logic [8:0] MASK_ALL = 9'h1FF;
  localparam logic [8:0] MASK_TWO = 9'b000001001;
  localparam logic [8:0] MASK_NONE = 9'h000;
  localparam int LAT_ALL  = popcount(64'(MASK_ALL));
  localparam int LAT_TWO  = popcount(64'(MASK_TWO));
  localparam int LAT_NONE = popcount(64'(MASK_NONE));
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic ov [4];
  logic [15:0] p [4];
  logic [7:0] y [4];
  logic of [4];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic hv [2048];
  logic hr [2048];
  logic [7:0] ha [2048];
  logic [7:0] hb [2048];
  always #5 clk = ~clk;
  array_multiplier #(.DATAWIDTH(8), .FRAC_BITS(0)) d0 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .A(A), .B(B),
    .o_valid(ov[0]), .P_out(p[0]), .Y_out(y[0]), .ovf(of[0]));
  array_multiplier #(.DATAWIDTH(8), .FRAC_BITS(4)) d1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .A(A), .B(B),
    .o_valid(ov[1]), .P_out(p[1]), .Y_out(y[1]), .ovf(of[1]));
  array_multiplier #(.DATAWIDTH(8), .FRAC_BITS(0), .PIPELINE_STAGE_MASK(MASK_TWO)) d2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .A(A), .B(B),
    .o_valid(ov[2]), .P_out(p[2]), .Y_out(y[2]), .ovf(of[2]));
  array_multiplier #(.DATAWIDTH(8), .FRAC_BITS(0), .PIPELINE_STAGE_MASK(MASK_NONE)) d3 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .A(A), .B(B),
    .o_valid(ov[3]), .P_out(p[3]), .Y_out(y[3]), .ovf(of[3]));
  function automatic logic [25:0] model(input int j, input int lat, input int f);
    int c;
    int pr;
    int q;
    c = j - lat;
    if (c < 0) return '0;
    for (int k = c; k <= j; k++) if (hr[k]) return '0;
    if (!hv[c]) return '0;
    pr = int'(ha[c]) * int'(hb[c]);
    q = pr >> f;
    return {1'b1, 16'(pr), (q > 255) ? 8'hFF : 8'(q), q > 255};
  endfunction
  function automatic logic [25:0] obs(input int d);
    return {ov[d], p[d], y[d], of[d]};
  endfunction
  task automatic chk(input string tag, input logic [25:0] got, input logic [25:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic step(input logic r_n, input logic v, input logic [7:0] a, input logic [7:0] b);
    rst = r_n;
    i_valid = v;
    A = a;
    B = b;
    hv[cyc] = v;
    hr[cyc] = !r_n;
    ha[cyc] = a;
    hb[cyc] = b;
    #1;
    chk("full_mask", obs(0), model(cyc, LAT_ALL, 0));
    chk("frac4", obs(1), model(cyc, LAT_ALL, 4));
    chk("mask_two", obs(2), model(cyc, LAT_TWO, 0));
    if (!hr[cyc]) chk("mask_none", obs(3), model(cyc, LAT_NONE, 0));
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 8'd0, 8'd0);
  endtask
  initial begin
    repeat (3) step(1'b0, 1'b1, 8'd5, 8'd7);
    chk("rst_zero", obs(0), 26'd0);
    idle(10);
    step(1'b1, 1'b1, 8'd13, 8'd11);
    chk("mask0_same_cycle", obs(3), {1'b1, 16'd143, 8'd143, 1'b0});
    idle(1);
    chk("mask2_latency", obs(2), {1'b1, 16'd143, 8'd143, 1'b0});
    idle(7);
    chk("mul13x11_lat9", obs(0), {1'b1, 16'd143, 8'd143, 1'b0});
    step(1'b1, 1'b1, 8'd255, 8'd255);
    idle(8);
    chk("sat_255x255", obs(0), {1'b1, 16'hFE01, 8'hFF, 1'b1});
    step(1'b1, 1'b1, 8'd0, 8'd200);
    idle(8);
    chk("zero_operand", obs(0), {1'b1, 16'd0, 8'd0, 1'b0});
    step(1'b1, 1'b1, 8'h18, 8'h28);
    idle(8);
    chk("fixed_point", obs(1), {1'b1, 16'h03C0, 8'h3C, 1'b0});
    for (int i = 0; i < 200; i++)
      step(1'b1, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
    idle(10);
    repeat (4) step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    step(1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 1'b1, 8'd77, 8'd3);
    idle(8);
    chk("post_reset_mul", obs(0), {1'b1, 16'd231, 8'd231, 1'b0});
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
